// File: rtl/celseq_pkg.sv
// -----------------------------------------------------------------------------
// celseq_pkg
// Shared types and constants for the C-element grid sequencer.
//   - state_e  : sequencer phase encoding (6 states)
//   - ROW_W / COL_W / OUT_W : grid row, column and decoded-output widths
//   - HOLD_ROW : row drive used while the grid holds (mixed inputs on every cell)
// -----------------------------------------------------------------------------
package celseq_pkg;

  localparam int ROW_W = 3;
  localparam int COL_W = 9;
  localparam int OUT_W = 9;

  // All rows high with all columns low gives each cell mixed inputs, so it holds.
  localparam logic [ROW_W-1:0] HOLD_ROW = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_APPLY  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

endpackage : celseq_pkg

// File: rtl/celseq_rr_arb2.sv
// -----------------------------------------------------------------------------
// celseq_rr_arb2
// Two-way round-robin grant. The grant itself is combinational; the
// last_grant register only advances when the owner strobes update.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset (last_grant -> 1,
//                  so requester 0 wins the first contested grant)
//   req0_valid   : requester 0 pending
//   req1_valid   : requester 1 pending
//   update       : commit grant_id as the new last_grant
//   grant        : at least one requester pending
//   grant_id     : requester selected this cycle
// -----------------------------------------------------------------------------
module celseq_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic update,
  output logic grant,
  output logic grant_id
);

  logic last_grant_q;
  logic last_grant_d;

  // Select a requester; on contention favour the one not served last.
  always_comb begin
    grant    = req0_valid | req1_valid;
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = req1_valid;
    end
    if (update) begin
      last_grant_d = grant_id;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Round-robin history register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule : celseq_rr_arb2

// File: rtl/celem_grid_sequencer.sv
// -----------------------------------------------------------------------------
// celem_grid_sequencer
// Controller and round-robin arbiter for the shared 3x3 C-element grid.
// A granted {row, col} pattern is run through CLEAR -> APPLY -> HOLD -> SAMPLE
// on the grid, and the grid's 9 decoded outputs are returned tagged with the
// requester ID. All outputs are registered.
//
// Optional build macro: CELSEQ_STABLE_CHECK_EN
//   Adds output res_unstable; SAMPLE takes two grid samples (A then B),
//   res_data = B and res_unstable = (A != B). Adds one cycle of latency.
//
// Ports:
//   clk, rst_n                : clock, synchronous active-low reset
//   reqN_valid/ready/row/col  : requester N pattern handshake (N = 0, 1);
//                               ready pulses for one cycle on acceptance
//   res_valid/ready/id/data   : result handshake, held until accepted
//   arr_clr/arr_row/arr_col   : grid drive (arr_clr forces all cell inputs low)
//   arr_out                   : grid decoded outputs
//   res_unstable              : (macro only) the two samples disagreed
// -----------------------------------------------------------------------------
module celem_grid_sequencer
  import celseq_pkg::*;
#(
  parameter int CLR_CYC    = 2,
  parameter int SETTLE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [ROW_W-1:0] req0_row,
  input  logic [COL_W-1:0] req0_col,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [ROW_W-1:0] req1_row,
  input  logic [COL_W-1:0] req1_col,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [OUT_W-1:0] res_data,
  output logic             arr_clr,
  output logic [ROW_W-1:0] arr_row,
  output logic [COL_W-1:0] arr_col,
  input  logic [OUT_W-1:0] arr_out
`ifdef CELSEQ_STABLE_CHECK_EN
  ,
  output logic             res_unstable
`endif
);

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [ROW_W-1:0] ROW_ZERO    = {ROW_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ZERO    = {COL_W{1'b0}};
  localparam logic [OUT_W-1:0] OUT_ZERO    = {OUT_W{1'b0}};

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             arr_clr_q,    arr_clr_d;
  logic [ROW_W-1:0] arr_row_q,    arr_row_d;
  logic [COL_W-1:0] arr_col_q,    arr_col_d;
  logic             req0_ready_q, req0_ready_d;
  logic             req1_ready_q, req1_ready_d;
  logic             res_valid_q,  res_valid_d;
  logic             res_id_q,     res_id_d;
  logic [OUT_W-1:0] res_data_q,   res_data_d;
  logic [ROW_W-1:0] lat_row_q,    lat_row_d;
  logic [COL_W-1:0] lat_col_q,    lat_col_d;
  logic             lat_id_q,     lat_id_d;
`ifdef CELSEQ_STABLE_CHECK_EN
  logic [OUT_W-1:0] samp_a_q,     samp_a_d;
  logic             res_unstable_q, res_unstable_d;
`endif

  logic grant_s;
  logic grant_id_s;
  logic arb_update_s;

  celseq_rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .update     (arb_update_s),
    .grant      (grant_s),
    .grant_id   (grant_id_s)
  );

  // Next-state and next-output logic. Grid drive is computed for the state
  // being entered, so the registered drive lines up with the state register.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    arr_clr_d    = arr_clr_q;
    arr_row_d    = arr_row_q;
    arr_col_d    = arr_col_q;
    req0_ready_d = 1'b0;
    req1_ready_d = 1'b0;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    res_data_d   = res_data_q;
    lat_row_d    = lat_row_q;
    lat_col_d    = lat_col_q;
    lat_id_d     = lat_id_q;
    arb_update_s = 1'b0;
`ifdef CELSEQ_STABLE_CHECK_EN
    samp_a_d       = samp_a_q;
    res_unstable_d = res_unstable_q;
`endif

    case (state_q)
      ST_IDLE: begin
        arr_clr_d   = 1'b1;
        arr_row_d   = ROW_ZERO;
        arr_col_d   = COL_ZERO;
        res_valid_d = 1'b0;
        cnt_d       = CNT_ZERO;
        if (grant_s) begin
          arb_update_s = 1'b1;
          lat_id_d     = grant_id_s;
          state_d      = ST_CLEAR;
          if (grant_id_s) begin
            req1_ready_d = 1'b1;
            lat_row_d    = req1_row;
            lat_col_d    = req1_col;
          end else begin
            req0_ready_d = 1'b1;
            lat_row_d    = req0_row;
            lat_col_d    = req0_col;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          state_d   = ST_APPLY;
          cnt_d     = CNT_ZERO;
          arr_clr_d = 1'b0;
          arr_row_d = lat_row_q;
          arr_col_d = lat_col_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_APPLY: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d   = ST_HOLD;
          cnt_d     = CNT_ZERO;
          arr_row_d = HOLD_ROW;
          arr_col_d = COL_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_SAMPLE: begin
`ifdef CELSEQ_STABLE_CHECK_EN
        // First cycle captures sample A; second captures B and compares.
        if (cnt_q == CNT_ZERO) begin
          samp_a_d = arr_out;
          cnt_d    = CNT_ONE;
        end else begin
          res_data_d     = arr_out;
          res_unstable_d = (samp_a_q != arr_out);
          res_valid_d    = 1'b1;
          res_id_d       = lat_id_q;
          state_d        = ST_RESP;
          cnt_d          = CNT_ZERO;
        end
`else
        res_data_d  = arr_out;
        res_valid_d = 1'b1;
        res_id_d    = lat_id_q;
        state_d     = ST_RESP;
        cnt_d       = CNT_ZERO;
`endif
      end

      ST_RESP: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
          cnt_d       = CNT_ZERO;
          arr_clr_d   = 1'b1;
          arr_row_d   = ROW_ZERO;
          arr_col_d   = COL_ZERO;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cnt_d       = CNT_ZERO;
        arr_clr_d   = 1'b1;
        arr_row_d   = ROW_ZERO;
        arr_col_d   = COL_ZERO;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State, counter, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      arr_clr_q    <= 1'b1;
      arr_row_q    <= ROW_ZERO;
      arr_col_q    <= COL_ZERO;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      res_data_q   <= OUT_ZERO;
      lat_row_q    <= ROW_ZERO;
      lat_col_q    <= COL_ZERO;
      lat_id_q     <= 1'b0;
`ifdef CELSEQ_STABLE_CHECK_EN
      samp_a_q       <= OUT_ZERO;
      res_unstable_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      arr_clr_q    <= arr_clr_d;
      arr_row_q    <= arr_row_d;
      arr_col_q    <= arr_col_d;
      req0_ready_q <= req0_ready_d;
      req1_ready_q <= req1_ready_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_data_q   <= res_data_d;
      lat_row_q    <= lat_row_d;
      lat_col_q    <= lat_col_d;
      lat_id_q     <= lat_id_d;
`ifdef CELSEQ_STABLE_CHECK_EN
      samp_a_q       <= samp_a_d;
      res_unstable_q <= res_unstable_d;
`endif
    end
  end

  assign req0_ready = req0_ready_q;
  assign req1_ready = req1_ready_q;
  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign res_data   = res_data_q;
  assign arr_clr    = arr_clr_q;
  assign arr_row    = arr_row_q;
  assign arr_col    = arr_col_q;
`ifdef CELSEQ_STABLE_CHECK_EN
  assign res_unstable = res_unstable_q;
`endif

endmodule : celem_grid_sequencer

// File: doc/celem_grid_sequencer.md
Name: celem_grid_sequencer

Overview:
- Controller and round-robin arbiter for the 3x3 C-element grid datapath.
- Each grid cell sets when its row and column inputs are both 1, clears when both are 0, and holds on mixed inputs. All grid inputs are forced to 0 while the grid clear input is high.
- Two requesters each submit a {row[2:0], col[8:0]} pattern. The block sequences clear -> apply -> hold -> sample on the shared grid and returns the grid's 9 decoded outputs, tagged with the requester ID.

Parameters:
- CLR_CYC, 2, cycles arr_clr is held high in CLEAR (>=1).
- SETTLE_CYC, 2, cycles the pattern is driven in APPLY (>=1).
- HOLD_CYC, 1, cycles in HOLD before sampling (>=1).
- CNT_W, 4, width of the phase counter; must hold max(CLR_CYC, SETTLE_CYC, HOLD_CYC).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req0_valid  in  1  requester 0 has a pattern.
- req0_ready  out  1  requester 0 pattern accepted this cycle.
- req0_row  in  3  requester 0 row vector.
- req0_col  in  9  requester 0 column vector.
- req1_valid, req1_ready, req1_row, req1_col  same widths and meaning for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_id  out  1  requester that owns the result.
- res_data  out  9  sampled grid outputs arr_out[8:0].
- arr_clr  out  1  grid clear; drives the grid's active-high gate input.
- arr_row  out  3  grid row inputs.
- arr_col  out  9  grid column inputs.
- arr_out  in  9  grid decoded outputs (row-OR, majority, any-set group).

Behaviour:
- Clock and reset: single clock domain. rst_n is synchronous and active-low. Everything below is registered on rising clk.
- Reset values:
  - state=IDLE, arr_clr=1, arr_row=0, arr_col=0.
  - req*_ready=0, res_valid=0, res_id=0, res_data=0, cnt=0.
  - last_grant=1, so req0 has priority first.
- States: IDLE, CLEAR, APPLY, HOLD, SAMPLE, RESP.
- IDLE:
  - arr_clr=1.
  - When any req*_valid is high: grant one requester. If both are valid, grant the one not equal to last_grant. Pulse that requester's req_ready for exactly one cycle (valid&ready = accept).
  - Latch the granted row/col and ID, set last_grant=ID, cnt=0, go to CLEAR.
- CLEAR: arr_clr=1, arr_row=0, arr_col=0 for CLR_CYC cycles, then go to APPLY.
- APPLY: arr_clr=0, arr_row/arr_col = latched pattern for SETTLE_CYC cycles, then go to HOLD.
- HOLD: arr_clr=0, arr_row=3'b111, arr_col=0 (mixed inputs, so every cell holds) for HOLD_CYC cycles, then go to SAMPLE.
- SAMPLE: one cycle. res_data<=arr_out, res_id<=latched ID, res_valid<=1, go to RESP. Grid stays in HOLD drive.
- RESP:
  - Hold res_valid, res_data and res_id stable until res_valid&res_ready.
  - Then res_valid<=0 in the next cycle, go to IDLE with arr_clr=1.
  - No new grant during RESP.
- Latency: accept to res_valid = CLR_CYC+SETTLE_CYC+HOLD_CYC+1 cycles (6 at defaults).
- Back-to-back: res_ready held high gives one idle cycle, then a grant.
- Requesters: must hold valid and data until ready. A request withdrawn before grant is not served.
- Reset mid-operation: abort immediately to the reset values. The in-flight request is dropped and no result is produced.
- Counter: cnt resets to 0 on each state change. The state exits when cnt==PARAM-1. There is no wrap, because the exit happens before overflow.

Optional Feature:
- Macro: CELSEQ_STABLE_CHECK_EN.
- With the macro defined:
  - Adds output res_unstable (1 bit).
  - SAMPLE becomes two cycles: sample A, then sample B.
  - res_data = sample B; res_unstable = (A != B). It is valid with res_valid, resets to 0.
  - Latency increases by 1.
- Without the macro: the port is absent and there is a single sample.

Decomposition:
- Shared package celseq_pkg: the state enum (6 encodings), ROW_W=3, COL_W=9, OUT_W=9, and the HOLD_ROW constant 3'b111.
- One natural sub-module: celseq_rr_arb2. It is the 2-way round-robin grant with a last_grant register and exposes grant, grant_id and an update strobe.

Test Plan:
- Reset, then idle: arr_clr=1, all ready/valid=0, res_data=0; a single req0 is granted first.
- req0 {row=3'b001, col=9'h007}, res_ready=1: req0_ready pulses once; arr_clr high for 2 cycles, pattern driven for 2, hold for 1; res_valid exactly 6 cycles after accept; res_id=0; res_data equals the golden grid-model output.
- req0 and req1 valid in the same cycle twice in a row: grant order 0,1,0,1; each res_id matches its grant.
- res_ready held low for 5 cycles: res_valid, res_data and res_id stay stable; no req*_ready pulses; release -> return to IDLE, next grant follows.
- rst_n low during APPLY: next cycle all outputs take their reset values; a following req1 completes normally with res_id=1.
- With CELSEQ_STABLE_CHECK_EN, grid model toggles arr_out bit 0 between samples: res_unstable=1, latency=7; with a stable model, res_unstable=0.
